// File: rtl/multi_digit_counter_display_if.sv
// Control and display signal bundle for multi_digit_counter_display.
// The master drives the counter controls; the slave (the counter) drives count, pulses and display pins.
interface multi_digit_counter_display_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  up_down;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic                  tick;
    logic                  wrap;
    logic [6:0]            abcdefg;
    logic [DIGITS-1:0]     digit_sel;

    modport master (
        output enable, up_down, load, load_value,
        input  count, tick, wrap, abcdefg, digit_sel
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output count, tick, wrap, abcdefg, digit_sel
    );
endinterface

// File: rtl/multi_digit_counter_display.sv
// Multi-digit BCD/hex up/down counter with tick prescaler, synchronous load and wrap flag,
// driving a time-multiplexed 7-segment display with optional leading-zero blanking.
module multi_digit_counter_display #(
    parameter int DIGITS    = 4,
    parameter int HEX_MODE  = 0,
    parameter int COUNT_DIV = 12_000_000,
    parameter int SCAN_DIV  = 3000,
    parameter int BLANK_LZ  = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    multi_digit_counter_display_if.slave  bus
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [3:0]    MAX_DIGIT  = (HEX_MODE != 0) ? 4'hF : 4'h9;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]    GLYPH_ZERO = 7'b1111110;

    logic [4*DIGITS-1:0] count_q;
    logic [PW-1:0]       presc_q;
    logic                tick_q;
    logic                wrap_q;
    logic [SW-1:0]       scan_cnt_q;
    logic [IW-1:0]       scan_idx_q;
    logic [DIGITS-1:0]   digit_sel_q;
    logic [6:0]          abcdefg_q;

    logic [4*DIGITS-1:0] count_step;
    logic                step_wrap;
    logic [4*DIGITS-1:0] load_clamped;
    logic [DIGITS-1:0]   blank_mask;
    logic                upper_zero;
    logic [3:0]          cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    seg_decode = 7'b1111110;
            4'h1:    seg_decode = 7'b0110000;
            4'h2:    seg_decode = 7'b1101101;
            4'h3:    seg_decode = 7'b1111001;
            4'h4:    seg_decode = 7'b0110011;
            4'h5:    seg_decode = 7'b1011011;
            4'h6:    seg_decode = 7'b1011111;
            4'h7:    seg_decode = 7'b1110000;
            4'h8:    seg_decode = 7'b1111111;
            4'h9:    seg_decode = 7'b1111011;
            4'hA:    seg_decode = 7'b1110111;
            4'hB:    seg_decode = 7'b0011111;
            4'hC:    seg_decode = 7'b1001110;
            4'hD:    seg_decode = 7'b0111101;
            4'hE:    seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    // Ripple carry/borrow: step_wrap starts as the incoming carry and survives only if every digit rolled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        count_step = count_q;
        step_wrap  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_wrap) begin
                if (bus.up_down) begin
                    if (count_q[4*i +: 4] == MAX_DIGIT) begin
                        count_step[4*i +: 4] = 4'h0;
                    end else begin
                        count_step[4*i +: 4] = count_q[4*i +: 4] + 4'h1;
                        step_wrap            = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'h0) begin
                        count_step[4*i +: 4] = MAX_DIGIT;
                    end else begin
                        count_step[4*i +: 4] = count_q[4*i +: 4] - 4'h1;
                        step_wrap            = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        load_clamped = bus.load_value;
        if (HEX_MODE == 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bus.load_value[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Digit i (i > 0) is blanked when it and all digits above it are zero.
    always_comb begin
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero    = upper_zero & (count_q[4*i +: 4] == 4'h0);
            blank_mask[i] = upper_zero && (BLANK_LZ != 0);
        end
    end

    assign cur_digit = count_q[4*scan_idx_q +: 4];

    // Load outranks a step on the same edge and restarts the prescaler.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (bus.enable && (presc_q == PRESC_LAST)) begin
            count_q <= count_step;
            presc_q <= '0;
            tick_q  <= 1'b1;
            wrap_q  <= step_wrap;
        end else begin
            if (bus.enable) presc_q <= presc_q + PW'(1);
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
        end else begin
            scan_cnt_q <= scan_cnt_q + SW'(1);
        end
    end

    // Select and segments are registered together so the pins never show a mismatched pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_sel_q <= DIGITS'(1);
            abcdefg_q   <= GLYPH_ZERO;
        end else begin
            digit_sel_q <= DIGITS'(1) << scan_idx_q;
            abcdefg_q   <= blank_mask[scan_idx_q] ? 7'b0000000 : seg_decode(cur_digit);
        end
    end

    assign bus.count     = count_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.abcdefg   = abcdefg_q;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Scoreboard bench: two counters (decimal, and hex with leading-zero blanking) share one stimulus stream;
// an integer-valued reference model queues expected outputs, a negedge monitor pops and compares.
module tb_multi_digit_counter_display;

    localparam int DIGITS    = 4;
    localparam int COUNT_DIV = 4;
    localparam int SCAN_DIV  = 2;

    typedef struct packed {
        logic [15:0] count;
        logic        tick;
        logic        wrap;
        logic [3:0]  sel;
        logic [6:0]  seg;
    } obs_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        up_down;
    logic        load;
    logic [15:0] load_value;

    always #5 clock = ~clock;

    multi_digit_counter_display_if #(.DIGITS(DIGITS)) bus0 ();
    multi_digit_counter_display_if #(.DIGITS(DIGITS)) bus1 ();

    assign bus0.enable     = enable;
    assign bus0.up_down    = up_down;
    assign bus0.load       = load;
    assign bus0.load_value = load_value;
    assign bus1.enable     = enable;
    assign bus1.up_down    = up_down;
    assign bus1.load       = load;
    assign bus1.load_value = load_value;

    multi_digit_counter_display #(
        .DIGITS(DIGITS), .HEX_MODE(0), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)
    ) dut_dec (
        .clock(clock), .reset(reset), .bus(bus0)
    );

    multi_digit_counter_display #(
        .DIGITS(DIGITS), .HEX_MODE(1), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)
    ) dut_hex (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    // Reference model state per configuration: the count is held as a plain integer.
    int   cfg_base  [2] = '{10, 16};
    bit   cfg_blank [2] = '{1'b0, 1'b1};
    int   m_val  [2];
    int   m_presc[2];
    int   m_scnt [2];
    int   m_sidx [2];
    bit   m_tick [2];
    bit   m_wrap [2];
    logic [3:0] m_sel [2];
    logic [6:0] m_seg [2];

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int mon_cyc      = 0;
    logic [15:0] rnd_lv;

    function automatic int pow_int(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic logic [15:0] to_bits(input int v, input int base);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow_int(base, i)) % base);
        return r;
    endfunction

    function automatic int load_to_val(input logic [15:0] lv, input int base);
        int v = 0;
        int nib;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(lv[4*i +: 4]);
            if (nib > base - 1) nib = base - 1;
            v = v + nib * pow_int(base, i);
        end
        return v;
    endfunction

    task automatic model_step(input int k, input bit rst, input bit en, input bit ud,
                              input bit ld, input logic [15:0] lv);
        int base = cfg_base[k];
        int modv = pow_int(base, DIGITS);
        int upper;
        upper    = m_val[k] / pow_int(base, m_sidx[k]);
        m_sel[k] = 4'(1 << m_sidx[k]);
        if (cfg_blank[k] && m_sidx[k] > 0 && upper == 0) m_seg[k] = 7'b0000000;
        else m_seg[k] = GLYPH[upper % base];
        if (m_scnt[k] == SCAN_DIV - 1) begin
            m_scnt[k] = 0;
            m_sidx[k] = (m_sidx[k] + 1) % DIGITS;
        end else begin
            m_scnt[k]++;
        end
        if (rst) begin
            m_val[k] = 0; m_presc[k] = 0; m_scnt[k] = 0; m_sidx[k] = 0;
            m_tick[k] = 1'b0; m_wrap[k] = 1'b0; m_sel[k] = 4'b0001; m_seg[k] = GLYPH[0];
        end else if (ld) begin
            m_val[k] = load_to_val(lv, base);
            m_presc[k] = 0; m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
        end else if (en && m_presc[k] == COUNT_DIV - 1) begin
            m_presc[k] = 0;
            m_tick[k]  = 1'b1;
            if (ud) begin
                m_wrap[k] = (m_val[k] == modv - 1);
                m_val[k]  = (m_val[k] + 1) % modv;
            end else begin
                m_wrap[k] = (m_val[k] == 0);
                m_val[k]  = (m_val[k] + modv - 1) % modv;
            end
        end else begin
            if (en) m_presc[k]++;
            m_tick[k] = 1'b0;
            m_wrap[k] = 1'b0;
        end
    endtask

    function automatic obs_t model_obs(input int k);
        return '{count: to_bits(m_val[k], cfg_base[k]), tick: m_tick[k], wrap: m_wrap[k],
                 sel: m_sel[k], seg: m_seg[k]};
    endfunction

    // Drive one clock of stimulus; the expected result of that edge is queued right after it.
    task automatic cycle(input bit rst, input bit en, input bit ud, input bit ld, input logic [15:0] lv);
        reset = rst; enable = en; up_down = ud; load = ld; load_value = lv;
        @(posedge clock);
        model_step(0, rst, en, ud, ld, lv);
        model_step(1, rst, en, ud, ld, lv);
        exp_q0.push_back(model_obs(0));
        exp_q1.push_back(model_obs(1));
        #1;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got count=%h tick=%b wrap=%b sel=%b seg=%b, expected count=%h tick=%b wrap=%b sel=%b seg=%b",
                     name, act.count, act.tick, act.wrap, act.sel, act.seg,
                     exp.count, exp.tick, exp.wrap, exp.sel, exp.seg);
        end
    endtask

    always @(negedge clock) begin
        obs_t act;
        if (exp_q0.size() > 0) begin
            act = '{count: bus0.count, tick: bus0.tick, wrap: bus0.wrap, sel: bus0.digit_sel, seg: bus0.abcdefg};
            check($sformatf("dec cycle %0d", mon_cyc), act, exp_q0.pop_front());
        end
        if (exp_q1.size() > 0) begin
            act = '{count: bus1.count, tick: bus1.tick, wrap: bus1.wrap, sel: bus1.digit_sel, seg: bus1.abcdefg};
            check($sformatf("hex_blank cycle %0d", mon_cyc), act, exp_q1.pop_front());
        end
        mon_cyc++;
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_presc[k] = 0; m_scnt[k] = 0; m_sidx[k] = 0;
            m_tick[k] = 1'b0; m_wrap[k] = 1'b0; m_sel[k] = 4'b0001; m_seg[k] = GLYPH[0];
        end

        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);

        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE);
        repeat (12) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0009);
        repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        for (int n = 0; n < 8 && m_presc[0] != COUNT_DIV - 1; n++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h12C4);
        repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0007);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0950);
        repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0:       rnd_lv = 16'h0000;
                1:       rnd_lv = 16'h9999;
                2:       rnd_lv = 16'hFFFF;
                default: rnd_lv = 16'($urandom);
            endcase
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 15) == 0, rnd_lv);
        end

        @(negedge clock);
        #1;
        n_compared++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: got %0d/%0d unchecked entries, expected 0/0", exp_q0.size(), exp_q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
